// File: rtl/top.sv
// Slicing machine controller: measures object length with an ultrasonic
// sensor, then alternates a track stepper (one slice pitch) and a cut stepper
// (one blade cycle) for the selected slice count, then raises finish_o.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start_i        start request (accepted in IDLE/DONE only)
//   pause_i        level pause, freezes stepping in MOVE/CUT
//   slice_i        slice-count select, doubles slice_num_o per sampled edge
//   slice_num_o    selected slice count (1,2,4,8,16)
//   finish_o       high once all slices are done
//   echo_i         ultrasonic echo input
//   trigger_o      ultrasonic trigger pulse
//   move_signal_o  track stepper phase drive (wave drive)
//   cut_signal_o   cut stepper phase drive (wave drive)
//
// Optional feature: define ECHO_TIMEOUT_EN to abandon WAIT_ECHO after 2^20
// cycles without an echo and return to IDLE. Without it WAIT_ECHO waits forever.
module top #(
    parameter real         define_speed = 0.0002,
    parameter int unsigned CLK_KHZ      = 50000,
    parameter int unsigned TRIG_CYCLES  = 500,
    parameter int unsigned ECHO_SHIFT   = 4,
    parameter int unsigned CUT_STEPS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       slice_i,
    output logic [4:0] slice_num_o,
    output logic       finish_o,
    input  logic       echo_i,
    output logic       trigger_o,
    output logic [3:0] move_signal_o,
    output logic [3:0] cut_signal_o
);

    // int' rounds, so floating-point error in the product cannot lose a cycle.
    localparam int          StepRaw     = int'(define_speed * real'(CLK_KHZ));
    localparam int unsigned STEP_CYCLES = (StepRaw < 1) ? 32'd1 : 32'(StepRaw);
`ifdef ECHO_TIMEOUT_EN
    localparam int unsigned EchoTimeout = 32'd1 << 20;
`endif

    typedef enum logic [2:0] {
        StIdle, StTrig, StWaitEcho, StMeasure, StMove, StCut, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [23:0] echo_cnt_q, echo_cnt_d;
    logic [23:0] per_slice_q, per_slice_d;
    logic [23:0] step_cnt_q, step_cnt_d;
    logic [4:0]  slices_left_q, slices_left_d;
    logic [1:0]  move_ph_q, move_ph_d;
    logic [1:0]  cut_ph_q, cut_ph_d;
    logic [4:0]  slice_num_q, slice_num_d;
    logic        finish_q, finish_d;
    logic        trigger_q, trigger_d;
    logic [3:0]  move_sig_q, move_sig_d;
    logic [3:0]  cut_sig_q, cut_sig_d;
    logic [23:0] total, per_calc;

    function automatic logic [3:0] wave(input logic [1:0] ph);
        return 4'b1000 >> ph;
    endfunction

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        echo_cnt_d    = echo_cnt_q;
        per_slice_d   = per_slice_q;
        step_cnt_d    = step_cnt_q;
        slices_left_d = slices_left_q;
        move_ph_d     = move_ph_q;
        cut_ph_d      = cut_ph_q;
        slice_num_d   = slice_num_q;
        finish_d      = finish_q;
        trigger_d     = 1'b0;
        total         = echo_cnt_q >> ECHO_SHIFT;
        // slice_num is always a power of two, so the divide is a shift.
        case (slice_num_q)
            5'd1:    per_calc = total;
            5'd2:    per_calc = total >> 1;
            5'd4:    per_calc = total >> 2;
            5'd8:    per_calc = total >> 3;
            default: per_calc = total >> 4;
        endcase

        unique case (state_q)
            StIdle, StDone: begin
                if (slice_i && slice_num_q != 5'd16) slice_num_d = slice_num_q << 1;
                if (start_i) begin
                    state_d   = StTrig;
                    timer_d   = '0;
                    finish_d  = 1'b0;
                    trigger_d = 1'b1;
                end
            end
            StTrig: begin
                if (timer_q == 24'(TRIG_CYCLES - 1)) begin
                    state_d = StWaitEcho;
                    timer_d = '0;
                end else begin
                    timer_d   = timer_q + 24'd1;
                    trigger_d = 1'b1;
                end
            end
            StWaitEcho: begin
                if (echo_i) begin
                    state_d    = StMeasure;
                    echo_cnt_d = 24'd1;
                end
`ifdef ECHO_TIMEOUT_EN
                else if (timer_q == 24'(EchoTimeout - 1)) begin
                    state_d  = StIdle;
                    timer_d  = '0;
                    finish_d = 1'b0;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
`endif
            end
            StMeasure: begin
                if (echo_i) begin
                    if (echo_cnt_q != {24{1'b1}}) echo_cnt_d = echo_cnt_q + 24'd1;
                end else begin
                    per_slice_d   = (per_calc == '0) ? 24'd1 : per_calc;
                    slices_left_d = slice_num_q;
                    timer_d       = '0;
                    step_cnt_d    = '0;
                    state_d       = StMove;
                end
            end
            StMove: begin
                if (!pause_i) begin
                    if (timer_q == 24'(STEP_CYCLES - 1)) begin
                        timer_d   = '0;
                        move_ph_d = move_ph_q + 2'd1;
                        if (step_cnt_q + 24'd1 == per_slice_q) begin
                            step_cnt_d = '0;
                            state_d    = StCut;
                        end else begin
                            step_cnt_d = step_cnt_q + 24'd1;
                        end
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
            end
            StCut: begin
                if (!pause_i) begin
                    if (timer_q == 24'(STEP_CYCLES - 1)) begin
                        timer_d  = '0;
                        cut_ph_d = cut_ph_q + 2'd1;
                        if (step_cnt_q + 24'd1 == 24'(CUT_STEPS)) begin
                            step_cnt_d    = '0;
                            slices_left_d = slices_left_q - 5'd1;
                            if (slices_left_q == 5'd1) begin
                                state_d  = StDone;
                                finish_d = 1'b1;
                            end else begin
                                state_d = StMove;
                            end
                        end else begin
                            step_cnt_d = step_cnt_q + 24'd1;
                        end
                    end else begin
                        timer_d = timer_q + 24'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state so they line up with the state.
        move_sig_d = (state_d == StMove && !pause_i) ? wave(move_ph_d) : 4'b0000;
        cut_sig_d  = (state_d == StCut && !pause_i) ? wave(cut_ph_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            echo_cnt_q    <= '0;
            per_slice_q   <= '0;
            step_cnt_q    <= '0;
            slices_left_q <= '0;
            move_ph_q     <= '0;
            cut_ph_q      <= '0;
            slice_num_q   <= 5'd1;
            finish_q      <= 1'b0;
            trigger_q     <= 1'b0;
            move_sig_q    <= 4'b0000;
            cut_sig_q     <= 4'b0000;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            echo_cnt_q    <= echo_cnt_d;
            per_slice_q   <= per_slice_d;
            step_cnt_q    <= step_cnt_d;
            slices_left_q <= slices_left_d;
            move_ph_q     <= move_ph_d;
            cut_ph_q      <= cut_ph_d;
            slice_num_q   <= slice_num_d;
            finish_q      <= finish_d;
            trigger_q     <= trigger_d;
            move_sig_q    <= move_sig_d;
            cut_sig_q     <= cut_sig_d;
        end
    end

    assign slice_num_o   = slice_num_q;
    assign finish_o      = finish_q;
    assign trigger_o     = trigger_q;
    assign move_signal_o = move_sig_q;
    assign cut_signal_o  = cut_sig_q;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the slicing machine: stimulus pushes expected trigger
// pulses, motor steps and finish events; a negedge monitor detects them on the
// DUT outputs and pops/compares.
module tb_top;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i = 1'b0;
    logic       pause_i = 1'b0;
    logic       slice_i = 1'b0;
    logic       echo_i = 1'b0;
    logic [4:0] slice_num_o;
    logic       finish_o;
    logic       trigger_o;
    logic [3:0] move_signal_o;
    logic [3:0] cut_signal_o;

    top dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .pause_i       (pause_i),
        .slice_i       (slice_i),
        .slice_num_o   (slice_num_o),
        .finish_o      (finish_o),
        .echo_i        (echo_i),
        .trigger_o     (trigger_o),
        .move_signal_o (move_signal_o),
        .cut_signal_o  (cut_signal_o)
    );

    always #5 clk = ~clk;

    localparam int EvTrig   = 0;
    localparam int EvStep   = 1;
    localparam int EvFinish = 2;

    typedef struct {
        int         kind;
        logic [7:0] pat;
        int         cycles;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [3:0] wave_tab[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    int         mph = 0;
    int         cph = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic pop_cmp(input int kind, input logic [7:0] pat, input int cyc);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: unexpected event kind %0d pat %0h, nothing required (t=%0t)",
                     kind, pat, $time);
            return;
        end
        e = exp_q.pop_front();
        check("event kind", kind, e.kind);
        if (e.kind == EvStep) begin
            check("step pattern", pat, e.pat);
            check("step cycles", cyc, e.cycles);
        end else if (e.kind == EvTrig) begin
            check("trigger width", cyc, e.cycles);
        end
    endtask

    // Monitor: counts displayed cycles per step (zero cycles from pause are skipped).
    logic [7:0] last_pat = '0;
    bit         step_on = 1'b0;
    int         step_cyc = 0;
    int         trig_cyc = 0;
    logic       fin_prev = 1'b0;

    always @(negedge clk) begin
        logic [7:0] cur;
        cur = {move_signal_o, cut_signal_o};
        if (!rst_n) begin
            step_on  = 1'b0;
            last_pat = '0;
            trig_cyc = 0;
            fin_prev = 1'b0;
        end else begin
            if (trigger_o) begin
                trig_cyc++;
            end else if (trig_cyc != 0) begin
                pop_cmp(EvTrig, 8'h00, trig_cyc);
                trig_cyc = 0;
            end
            if (cur != 8'h00) begin
                if (step_on && cur == last_pat) begin
                    step_cyc++;
                end else begin
                    if (step_on) pop_cmp(EvStep, last_pat, step_cyc);
                    step_on  = 1'b1;
                    last_pat = cur;
                    step_cyc = 1;
                end
            end
            if (finish_o && !fin_prev) begin
                if (step_on) pop_cmp(EvStep, last_pat, step_cyc);
                step_on = 1'b0;
                pop_cmp(EvFinish, 8'h00, 0);
            end
            fin_prev = finish_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Expected step sequence: per move steps then 8 cut steps, 10 cycles each.
    task automatic push_run(input int slices, input int per);
        for (int s = 0; s < slices; s++) begin
            for (int i = 0; i < per; i++) begin
                exp_q.push_back('{kind: EvStep, pat: {wave_tab[mph], 4'b0000}, cycles: 10});
                mph = (mph + 1) % 4;
            end
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back('{kind: EvStep, pat: {4'b0000, wave_tab[cph]}, cycles: 10});
                cph = (cph + 1) % 4;
            end
        end
        exp_q.push_back('{kind: EvFinish, pat: 8'h00, cycles: 0});
    endtask

    task automatic do_run(input int echo_len, input int slices, input int per,
                          input int fin_bound, input bit do_pause);
        int n;
        int el;
        exp_q.push_back('{kind: EvTrig, pat: 8'h00, cycles: 500});
        pulse_start();
        check("trigger high after start", trigger_o, 1);
        check("finish cleared on start", finish_o, 0);
        n = 0;
        while (trigger_o && n < 700) begin
            @(negedge clk);
            n++;
        end
        check("trigger ends in time", trigger_o, 0);
        tick(3);
        push_run(slices, per);
        echo_i = 1'b1;
        tick(echo_len);
        echo_i = 1'b0;
        el = 0;
        if (do_pause) begin
            tick(35);
            check("move active before pause", move_signal_o != 4'b0000, 1);
            pause_i = 1'b1;
            tick(3);
            check("move output in pause", move_signal_o, 4'b0000);
            check("cut output in pause", cut_signal_o, 4'b0000);
            tick(47);
            pause_i = 1'b0;
            tick(12);
            pulse_start();
            check("start ignored in move", trigger_o, 0);
            el = 98;
        end
        while (!finish_o && el < fin_bound) begin
            @(negedge clk);
            el++;
        end
        check("finish within bound", finish_o, 1);
        tick(5);
        check("finish held", finish_o, 1);
        check("motors idle in done", {move_signal_o, cut_signal_o}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        tick(3);
        check("reset slice_num", slice_num_o, 5'd1);
        check("reset finish", finish_o, 0);
        check("reset trigger", trigger_o, 0);
        check("reset move", move_signal_o, 4'b0000);
        check("reset cut", cut_signal_o, 4'b0000);
        rst_n = 1'b1;
        tick(2);

        slice_i = 1'b1;
        tick(2);
        slice_i = 1'b0;
        tick(1);
        check("slice two edges", slice_num_o, 5'd4);

        // 900-cycle echo, 4 slices: 900>>4=56, 56/4=14 steps per slice.
        do_run(900, 4, 14, 1000, 1'b1);

        slice_i = 1'b1;
        tick(1);
        slice_i = 1'b0;
        tick(1);
        check("slice in done", slice_num_o, 5'd8);

        // 300>>4=18, 18/8=2.
        do_run(300, 8, 2, 1000, 1'b0);

        slice_i = 1'b1;
        tick(5);
        slice_i = 1'b0;
        tick(1);
        check("slice saturates", slice_num_o, 5'd16);

        // 100>>4=6, 6/16=0 -> clamped to 1.
        do_run(100, 16, 1, 2000, 1'b0);

        // Reset in the middle of a trigger pulse.
        pulse_start();
        tick(20);
        check("trigger before reset", trigger_o, 1);
        rst_n = 1'b0;
        tick(2);
        check("midrun reset slice_num", slice_num_o, 5'd1);
        check("midrun reset trigger", trigger_o, 0);
        check("midrun reset finish", finish_o, 0);
        rst_n = 1'b1;
        tick(5);
        check("idle after reset", {trigger_o, move_signal_o, cut_signal_o}, 9'h000);

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Top level of an automatic slicing machine.
- Measures object length with an ultrasonic sensor, then alternates two stepper motors:
  - track motor advances the object by one slice pitch;
  - cut motor performs one full blade cycle.
- Repeats for the user-selected slice count, then signals completion.
- Contains controller FSM, ultrasonic interface, slice counter, track driver and cut driver as internal logic.

Parameters:
- define_speed, 0.0002, real: stepper step period in milliseconds.
- CLK_KHZ, 50000, integer: clock frequency in kHz. STEP_CYCLES = integer(define_speed*CLK_KHZ), minimum 1; default gives 10.
- TRIG_CYCLES, 500, integer: trigger pulse width in cycles (10 us at 50 MHz).
- ECHO_SHIFT, 4, integer: right shift converting echo cycles to total track steps.
- CUT_STEPS, 8, integer: cut-motor steps per blade cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request, sampled at rising clk.
- pause_i  in  1  pause, level-sensitive, high = pause.
- slice_i  in  1  slice-count select, sampled at rising clk.
- slice_num_o  out  5  selected slice count (1,2,4,8,16).
- finish_o  out  1  high when all slices done.
- echo_i  in  1  ultrasonic echo; high time proportional to distance.
- trigger_o  out  1  ultrasonic trigger pulse.
- move_signal_o  out  4  track stepper phase drive.
- cut_signal_o  out  4  cut stepper phase drive.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values: slice_num_o=1, finish_o=0, trigger_o=0, move_signal_o=0000, cut_signal_o=0000, FSM=IDLE, all counters 0.
- Slice counter (IDLE or DONE only):
  - every clock edge with slice_i=1 doubles slice_num_o; saturates at 16;
  - slice_i is level-sampled, not edge-detected, so a 2-cycle high gives 1→4;
  - ignored in all other states.
- Motor drive: wave drive sequence 1000→0100→0010→0001→1000, one advance per STEP_CYCLES cycles. Output is 0000 whenever that motor is not stepping.
- FSM states:
  - IDLE: on start_i=1, go to TRIG and clear finish_o.
  - TRIG: trigger_o=1 for exactly TRIG_CYCLES cycles, then trigger_o=0; go to WAIT_ECHO.
  - WAIT_ECHO: wait for echo_i=1; go to MEASURE.
  - MEASURE: count cycles with echo_i=1 (24-bit, saturating). On echo_i=0, compute:
    - total = count>>ECHO_SHIFT;
    - per_slice = total>>log2(slice_num_o), minimum 1;
    - go to MOVE with slices_left = slice_num_o.
  - MOVE: track motor issues per_slice steps; go to CUT.
  - CUT: cut motor issues CUT_STEPS steps; decrement slices_left. If 0 go to DONE, else MOVE.
  - DONE: finish_o=1, held. start_i=1 restarts at TRIG with finish_o cleared.
- Pause:
  - in MOVE or CUT while pause_i=1: step timer and step counters freeze, both motor outputs are 0000;
  - on release, resume from the frozen phase and count;
  - ignored in other states (trigger/echo timing is not pausable).
- start_i outside IDLE/DONE is ignored.
- Reset mid-operation returns everything immediately to reset values.
- Example: echo 900 cycles with slice_num 4 gives total 56, per_slice 14. Sequence is 4×(14 track + 8 cut) steps at 10 cycles/step, ≈880 cycles.

Optional Feature:
- ECHO_TIMEOUT_EN defined: if echo_i does not rise within 2^20 cycles in WAIT_ECHO, return to IDLE with finish_o=0 and motors idle.
- Not defined: WAIT_ECHO waits indefinitely.

Test Plan:
- Reset: rst_n=0 → slice_num_o=1, finish_o=0, trigger_o=0, both motor outputs 0000.
- Slice select: slice_i high for 2 consecutive edges → slice_num_o=4. Further 5 high edges → saturates at 16.
- Trigger: start_i (one edge, pause_i=0) → trigger_o high exactly 500 cycles, starting the cycle after start.
- Full run:
  - stimulus: slice_num 4; echo_i high 900 cycles after the trigger;
  - required: 4 groups of 14 move steps then 8 cut steps, each step 10 cycles, 1000→0100→0010→0001 order;
  - finish_o rises after the last cut step, within 1000 cycles of echo fall.
- Pause: pause_i=1 for 50 cycles mid-MOVE → both motor outputs 0000. Step count resumes unchanged; total move steps are still 14 for that slice.
- Restart: start_i in DONE → finish_o clears, new trigger pulse. start_i during MOVE has no effect.
